mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have port i_clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports i_if_req  in  1  and i_if_addr  in  32: instruction-fetch read request and word address.
REQ-004 SHALL have ports o_if_ack  out  1 (request accepted this cycle), o_if_rvalid  out  1 and o_if_rdata  out  32 (fetch response).
REQ-005 SHALL have ports i_ls_req  in  1, i_ls_we  in  1, i_ls_addr  in  32, i_ls_wdata  in  32, i_ls_bmask  in  4: load/store request.
REQ-006 SHALL have ports o_ls_ack  out  1, o_ls_rvalid  out  1, o_ls_rdata  out  32: load/store accept and response; rvalid also pulses for stores.
REQ-007 SHALL have ports i_flush  in  1: pipeline redirect (mispredict), which cancels the fetch response.
REQ-008 SHALL have ports o_mem_req  out  1, o_mem_we  out  1, o_mem_addr  out  32, o_mem_wdata  out  32, o_mem_bmask  out  4, i_mem_ack  in  1, i_mem_rdata  in  32: shared memory port.
REQ-009 SHALL have port o_busy  out  1: high whenever the state is not IDLE.
REQ-010 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive LS grants allowed while IF waits.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY_IF and BUSY_LS.
REQ-012 In IDLE with at least one request, SHALL assert exactly one of o_if_ack/o_ls_ack combinationally in that cycle and SHALL NOT assert either outside IDLE.
REQ-013 Priority rule: LS wins a conflict unless the starvation count equals STARVE_MAX, in which case IF wins.
REQ-014 Starvation count SHALL increment (saturating at STARVE_MAX) on each LS grant made while i_if_req is high, and SHALL clear on every IF grant.
REQ-015 On the accepting edge, the selected address, we, wdata and bmask SHALL be registered, and the state SHALL move to BUSY_IF or BUSY_LS. IF grants SHALL drive we=0 and bmask=4'hF.
REQ-016 o_mem_req SHALL be registered, high from the cycle after accept through the cycle in which i_mem_ack is sampled high. o_mem_* fields SHALL stay stable during that interval.
REQ-017 On the edge sampling i_mem_ack=1 in a BUSY state, SHALL capture i_mem_rdata into the matching rdata register, pulse the matching rvalid for exactly 1 cycle, and return to IDLE.
REQ-018 Minimum latency SHALL be: ack in cycle N, o_mem_req in cycle N+1, rvalid in cycle N+2 if memory acks in N+1. A new accept SHALL be possible in cycle N+2.
REQ-019 i_mem_ack while IDLE SHALL be ignored.
REQ-020 A kill flag SHALL be set if i_flush=1 in the IF-accept cycle or at any cycle during BUSY_IF. The in-flight memory read SHALL still complete, but o_if_rvalid SHALL be suppressed for that transaction. The kill flag SHALL clear on return to IDLE.
REQ-021 i_flush SHALL have no effect on LS transactions. i_flush in IDLE without an IF accept SHALL have no effect.
REQ-022 o_if_rdata/o_ls_rdata SHALL hold their last captured value between responses.

Reset
REQ-023 When i_reset=0, SHALL asynchronously force: state IDLE; o_mem_req, o_if_rvalid, o_ls_rvalid, o_busy, kill flag and starvation count to 0; all o_mem_* fields and rdata registers to 32'h0/4'h0.
REQ-024 Reset asserted mid-transaction SHALL drop o_mem_req immediately with no rvalid. The first accept SHALL occur in the first IDLE cycle with a request after release.

Verification
REQ-025 Single fetch: i_if_req=1, addr 0x0000_0010 in cycle 0; mem acks in cycle 1 with 0x0000_0013 -> o_if_ack cycle 0, o_mem_addr=0x10 cycle 1, o_if_rvalid=1 with rdata 0x13 in cycle 2.
REQ-026 Conflict: both requesting in IDLE, LS store addr 0x100, wdata 0xDEADBEEF, bmask 4'b0011 -> o_ls_ack, o_mem_we=1, bmask 0011. IF is accepted on the next IDLE cycle.
REQ-027 Starvation: both requesting continuously with 1-cycle memory and STARVE_MAX=4 -> grant order LS,LS,LS,LS,IF,LS...
REQ-028 Flush: IF accepted, i_flush pulsed during BUSY_IF, memory acks 3 cycles later -> o_if_rvalid never asserted, o_busy falls, and the next request is accepted normally.
REQ-029 Reset: i_reset=0 for 1 cycle while o_mem_req=1 in BUSY_LS -> o_mem_req=0 and o_busy=0 immediately, with no o_ls_rvalid pulse.
REQ-030 Stall: i_mem_ack held 0 for 10 cycles -> o_mem_req and o_mem_addr stable throughout, no acks issued, and o_busy=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch (IF) client and a
//   load/store (LS) client. One transaction is in flight at a time.
//   LS normally wins a conflict; after STARVE_MAX consecutive LS grants made
//   while IF was waiting, IF is given the next grant.
//
// Ports
//   i_clk, i_reset            clock, asynchronous active-low reset
//   i_if_req/i_if_addr        fetch read request
//   o_if_ack/o_if_rvalid/o_if_rdata   fetch accept (combinational) and response
//   i_ls_req/_we/_addr/_wdata/_bmask  load/store request
//   o_ls_ack/o_ls_rvalid/o_ls_rdata   load/store accept and response
//   i_flush                   cancels the response of the current fetch
//   o_mem_*, i_mem_ack, i_mem_rdata   shared memory port
//   o_busy                    a transaction is in flight
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ack,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_bmask,
  output logic        o_ls_ack,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  input  logic        i_flush,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  state_t        state_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          kill_q;
  logic          mem_req_q, mem_we_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;
  logic [3:0]    mem_bmask_q;
  logic          if_rvalid_q, ls_rvalid_q;
  logic [31:0]   if_rdata_q, ls_rdata_q;

  logic starved, if_grant, ls_grant;

  // Grants are only ever issued from IDLE, and never while reset is held.
  always_comb begin
    starved  = (starve_q == STARVE_LIM);
    if_grant = i_reset && (state_q == IDLE) && i_if_req && (!i_ls_req || starved);
    ls_grant = i_reset && (state_q == IDLE) && i_ls_req && !if_grant;
  end

  // Starvation count: only LS grants that bypass a waiting IF count.
  always_comb begin
    starve_d = starve_q;
    if (if_grant)
      starve_d = '0;
    else if (ls_grant && i_if_req && !starved)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_bmask_q <= 4'h0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'h0;
      ls_rdata_q  <= 32'h0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      starve_q    <= starve_d;
      case (state_q)
        IDLE: begin
          if (if_grant) begin
            state_q     <= BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_if_addr;
            mem_wdata_q <= 32'h0;
            mem_bmask_q <= 4'hF;
            kill_q      <= i_flush;
          end else if (ls_grant) begin
            state_q     <= BUSY_LS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= i_ls_we;
            mem_addr_q  <= i_ls_addr;
            mem_wdata_q <= i_ls_wdata;
            mem_bmask_q <= i_ls_bmask;
          end
        end
        BUSY_IF: begin
          if (i_flush) kill_q <= 1'b1;
          if (i_mem_ack) begin
            // A flush arriving in the ack cycle still cancels the response.
            if_rdata_q  <= i_mem_rdata;
            if_rvalid_q <= !(kill_q || i_flush);
            mem_req_q   <= 1'b0;
            kill_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        BUSY_LS: begin
          if (i_mem_ack) begin
            ls_rdata_q  <= i_mem_rdata;
            ls_rvalid_q <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_if_ack    = if_grant;
  assign o_ls_ack    = ls_grant;
  assign o_if_rvalid = if_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_rvalid = ls_rvalid_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_bmask = mem_bmask_q;
  assign o_busy      = (state_q != IDLE);

endmodule
